// File: rtl/reg_dump_uart_pkg.sv
// Shared definitions for the register-dump UART block.
// Holds the default bit period, the register-index width, the FSM state
// encoding and a helper that picks one byte of a word in send order.
package reg_dump_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200 baud
    localparam int REG_IDX_W            = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    // Byte idx of a word in big-endian send order (idx 0 = bits 31:24).
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        b = word[7:0];
        case (idx)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reg_dump_uart_if.sv
// Bus bundle between the dump engine and its surroundings.
//   start   : single-cycle dump request (host -> engine)
//   rd_addr : register-file read address (engine -> register file)
//   rd_data : combinational read data for rd_addr (register file -> engine)
//   tx      : UART serial line, idle high (engine -> pin)
//   busy    : dump in progress
//   done    : one-cycle pulse when the dump has finished
// slave is the engine's view, master the host/register-file view.
interface reg_dump_uart_if;
    import reg_dump_uart_pkg::*;

    logic                 start;
    logic [REG_IDX_W-1:0] rd_addr;
    logic [31:0]          rd_data;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (output start, rd_data, input rd_addr, tx, busy, done);
    modport slave  (input start, rd_data, output rd_addr, tx, busy, done);
endinterface

// File: rtl/reg_dump_uart_uart_tx.sv
// 8N1 UART transmitter.
//   clk, reset : clock, async active-high reset
//   data       : byte to send, taken when valid && ready
//   valid      : byte offered
//   tx         : serial line, high when idle
//   ready      : a new byte may be taken this cycle
// ready is also raised in the final cycle of the stop bit, so a byte offered
// then starts its start bit with no idle gap.
module uart_tx
    import reg_dump_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       tx,
    output logic       ready
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             active;
    logic [9:0]       frame;      // {stop, data[7:0], start}, shifted out LSB first
    logic [3:0]       bits_left;
    logic [CNT_W-1:0] bit_cnt;    // down-counter, bit ends at terminal count 0

    assign ready = !active || (bits_left == 4'd0 && bit_cnt == '0);
    assign tx    = active ? frame[0] : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active    <= 1'b0;
            frame     <= '0;
            bits_left <= '0;
            bit_cnt   <= '0;
        end else if (ready && valid) begin
            active    <= 1'b1;
            frame     <= {1'b1, data, 1'b0};
            bits_left <= 4'd9;
            bit_cnt   <= BIT_LAST;
        end else if (active) begin
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - CNT_W'(1);
            end else if (bits_left != 4'd0) begin
                frame     <= {1'b1, frame[9:1]};
                bits_left <= bits_left - 4'd1;
                bit_cnt   <= BIT_LAST;
            end else begin
                active <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/reg_dump_uart.sv
// Register dump over UART: on start, reads registers FIRST_REG..LAST_REG
// one at a time and sends each 32-bit word as four 8N1 bytes, MSB byte first.
//   clk, reset : clock, async active-high reset
//   bus        : reg_dump_uart_if.slave (start, rd_addr, rd_data, tx, busy, done)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; rd_addr = 0
// ADDR    | rd_addr driven with the current index, read data settling
// CAPTURE | word snapshotted, byte 0 handed to the transmitter
// SEND    | bytes 1..3 handed over as the transmitter frees up
// NEXT    | last stop bit finished; step index or finish (done pulse)
module reg_dump_uart
    import reg_dump_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIRST_REG    = 1,
    parameter int LAST_REG     = 31
) (
    input  logic             clk,
    input  logic             reset,
    reg_dump_uart_if.slave   bus
);
    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    state_t               state, state_nxt;
    logic [REG_IDX_W-1:0] index, index_nxt;
    logic [31:0]          snapshot, snapshot_nxt;
    logic [1:0]           byte_cnt, byte_cnt_nxt;   // byte currently in flight
    logic                 tx_valid, tx_ready;
    logic [7:0]           tx_data;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .valid (tx_valid),
        .tx    (bus.tx),
        .ready (tx_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            index    <= '0;
            snapshot <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            index    <= index_nxt;
            snapshot <= snapshot_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        index_nxt    = index;
        snapshot_nxt = snapshot;
        byte_cnt_nxt = byte_cnt;
        tx_valid     = 1'b0;
        tx_data      = word_byte(snapshot, byte_cnt + 2'd1);
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    index_nxt = FIRST_IDX;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                // Byte 0 leaves straight from the read port (same value being
                // latched) to keep the inter-word gap short.
                snapshot_nxt = bus.rd_data;
                byte_cnt_nxt = 2'd0;
                tx_valid     = 1'b1;
                tx_data      = bus.rd_data[31:24];
                state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (byte_cnt == 2'd3) begin
                        state_nxt = ST_NEXT;
                    end else begin
                        tx_valid     = 1'b1;
                        byte_cnt_nxt = byte_cnt + 2'd1;
                    end
                end
            end
            ST_NEXT: begin
                if (index == LAST_IDX) begin
                    index_nxt = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    index_nxt = index + REG_IDX_W'(1);
                    state_nxt = ST_ADDR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.rd_addr = index;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_NEXT) && (index == LAST_IDX);
endmodule

// File: tb/tb_reg_dump_uart.sv
module tb_reg_dump_uart;
    import reg_dump_uart_pkg::*;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic        start_s [2];
    logic [31:0] regs [2][32];

    always #5 clk = ~clk;

    reg_dump_uart_if bus_a ();
    reg_dump_uart_if bus_b ();

    reg_dump_uart #(.CLKS_PER_BIT(CPB), .FIRST_REG(5), .LAST_REG(5)) dut_a (
        .clk(clk), .reset(rst[0]), .bus(bus_a.slave));
    reg_dump_uart #(.CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .reset(rst[1]), .bus(bus_b.slave));

    assign bus_a.start   = start_s[0];
    assign bus_b.start   = start_s[1];
    assign bus_a.rd_data = regs[0][bus_a.rd_addr];
    assign bus_b.rd_data = regs[1][bus_b.rd_addr];

    logic       tx_o [2], busy_o [2], done_o [2];
    logic [4:0] addr_o [2];
    assign tx_o[0] = bus_a.tx;       assign tx_o[1] = bus_b.tx;
    assign busy_o[0] = bus_a.busy;   assign busy_o[1] = bus_b.busy;
    assign done_o[0] = bus_a.done;   assign done_o[1] = bus_b.done;
    assign addr_o[0] = bus_a.rd_addr; assign addr_o[1] = bus_b.rd_addr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_of(input int g); return (g == 0) ? 5 : 1;  endfunction
    function automatic int last_of(input int g);  return (g == 0) ? 5 : 31; endfunction

    // Behavioural model: dump active flag, expected byte list, UART receiver.
    bit         m_act [2];
    bit         first_cyc [2];
    logic [7:0] exp_mem [2][128];
    logic [7:0] rx_log [2][128];
    int         exp_n [2], rx_n [2], ph [2], idle_run [2], done_cnt [2];
    logic [39:0] smp [2];
    logic       hold_ok;
    logic [7:0] rx_byte;

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_act[g] = 0; first_cyc[g] = 0; exp_n[g] = 0; rx_n[g] = 0;
            ph[g] = 0; idle_run[g] = 0; done_cnt[g] = 0; smp[g] = '0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                check($sformatf("reset_outputs%0d", g),
                      {tx_o[g], busy_o[g], done_o[g], addr_o[g]}, {1'b1, 1'b0, 1'b0, 5'd0});
                m_act[g] = 0;
                ph[g]    = 0;
            end else if (!m_act[g]) begin
                check($sformatf("idle_outputs%0d", g),
                      {tx_o[g], busy_o[g], done_o[g], addr_o[g]}, {1'b1, 1'b0, 1'b0, 5'd0});
                if (start_s[g]) begin
                    m_act[g] = 1; first_cyc[g] = 1;
                    exp_n[g] = 0; rx_n[g] = 0; ph[g] = 0; idle_run[g] = 0;
                    for (int r = first_of(g); r <= last_of(g); r++)
                        for (int k = 3; k >= 0; k--) begin
                            exp_mem[g][exp_n[g]] = regs[g][r][8*k +: 8];
                            exp_n[g]++;
                        end
                end
            end else begin
                if (!done_o[g]) check($sformatf("busy%0d", g), busy_o[g], 1);
                if (first_cyc[g]) begin
                    check($sformatf("first_addr%0d", g), addr_o[g], first_of(g));
                    first_cyc[g] = 0;
                end
                if (done_o[g]) begin
                    check($sformatf("done_mid_frame%0d", g), ph[g], 0);
                    check($sformatf("done_byte_count%0d", g), rx_n[g], exp_n[g]);
                    check($sformatf("done_delay%0d", g), idle_run[g] <= 3, 1);
                    done_cnt[g]++;
                    m_act[g] = 0;
                end else if (ph[g] == 0) begin
                    if (tx_o[g] == 1'b0) begin
                        if (rx_n[g] > 0)
                            check($sformatf("frame_gap%0d", g), idle_run[g] <= 3, 1);
                        check($sformatf("addr_at_byte%0d_%0d", g, rx_n[g]),
                              addr_o[g], first_of(g) + rx_n[g] / 4);
                        smp[g][0] = 1'b0;
                        ph[g] = 1;
                        idle_run[g] = 0;
                    end else begin
                        idle_run[g]++;
                    end
                end else begin
                    smp[g][ph[g]] = tx_o[g];
                    ph[g]++;
                    if (ph[g] == 40) begin
                        hold_ok = 1'b1;
                        for (int b = 0; b < 10; b++)
                            for (int s = 1; s < 4; s++)
                                if (smp[g][4*b+s] !== smp[g][4*b]) hold_ok = 1'b0;
                        check($sformatf("bit_hold%0d", g), hold_ok, 1);
                        check($sformatf("stop_bit%0d", g), smp[g][36], 1);
                        for (int i = 0; i < 8; i++) rx_byte[i] = smp[g][4*(i+1)];
                        if (rx_n[g] < exp_n[g]) begin
                            check($sformatf("byte%0d_%0d", g, rx_n[g]), rx_byte, exp_mem[g][rx_n[g]]);
                            rx_log[g][rx_n[g]] = rx_byte;
                            rx_n[g]++;
                        end else begin
                            check($sformatf("extra_frame%0d", g), rx_n[g] + 1, exp_n[g]);
                        end
                        ph[g] = 0;
                        idle_run[g] = 0;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input int g);
        start_s[g] = 1'b1;
        cyc(1);
        start_s[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int target, input int budget);
        int n = 0;
        while (done_cnt[g] < target && n < budget) begin cyc(1); n++; end
        check($sformatf("done_timeout%0d", g), done_cnt[g] >= target, 1);
    endtask

    task automatic fill_random(input int g);
        for (int i = 0; i < 32; i++) regs[g][i] = $urandom;
    endtask

    int tgt, n;

    initial begin
        rst = 2'b11;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        fill_random(0); fill_random(1);
        cyc(3);
        rst = 2'b00;

        // Quiet period: monitor checks idle outputs every cycle.
        cyc(100);
        check("no_done_while_idle_a", done_cnt[0], 0);
        check("no_done_while_idle_b", done_cnt[1], 0);

        // Single register dump.
        regs[0][5] = 32'h12345678;
        pulse(0);
        wait_done(0, 1, 1000);
        cyc(2);
        check("single_count", rx_n[0], 4);
        check("single_b0", rx_log[0][0], 8'h12);
        check("single_b1", rx_log[0][1], 8'h34);
        check("single_b2", rx_log[0][2], 8'h56);
        check("single_b3", rx_log[0][3], 8'h78);
        check("single_done_cnt", done_cnt[0], 1);

        // Register changes after capture must not reach the line.
        pulse(0);
        cyc(3);
        regs[0][5] = 32'hFFFFFFFF;
        wait_done(0, 2, 1000);
        cyc(2);
        check("snap_b0", rx_log[0][0], 8'h12);
        check("snap_b3", rx_log[0][3], 8'h78);

        // Random single words, start held high across done (ignored in the
        // done cycle, accepted in the following idle cycle).
        for (int k = 0; k < 3; k++) begin
            regs[0][5] = $urandom;
            tgt = done_cnt[0] + 2;
            start_s[0] = 1'b1;
            n = 0;
            while (done_cnt[0] < tgt && n < 2000) begin cyc(1); n++; end
            start_s[0] = 1'b0;
            check("held_start_timeout", done_cnt[0] >= tgt, 1);
            cyc(3);
        end
        check("held_start_dumps", done_cnt[0], 8);

        // Full default dump, reg i = i * 0x01010101.
        for (int i = 0; i < 32; i++) regs[1][i] = i * 32'h01010101;
        pulse(1);
        wait_done(1, 1, 8000);
        cyc(2);
        check("full_count", rx_n[1], 124);
        check("full_first", rx_log[1][0], 8'h01);
        check("full_fifth", rx_log[1][4], 8'h02);
        check("full_last", rx_log[1][123], 8'h1F);
        check("full_done_cnt", done_cnt[1], 1);

        // Same dump with start pulses every 7 cycles.
        tgt = done_cnt[1] + 1;
        pulse(1);
        n = 0;
        while (done_cnt[1] < tgt && n < 9000) begin
            cyc(6);
            n += 7;
            if (done_cnt[1] < tgt) pulse(1);
        end
        check("spam_timeout", done_cnt[1] >= tgt, 1);
        cyc(3);
        check("spam_count", rx_n[1], 124);
        check("spam_last", rx_log[1][123], 8'h1F);
        check("spam_done_cnt", done_cnt[1], 2);

        // Random full dump.
        fill_random(1);
        pulse(1);
        wait_done(1, 3, 8000);
        cyc(2);
        check("rand_count", rx_n[1], 124);

        // Reset in the middle of a data bit of byte 2, then a fresh dump.
        fill_random(1);
        pulse(1);
        n = 0;
        while (!(rx_n[1] == 2 && ph[1] == 14) && n < 500) begin cyc(1); n++; end
        check("mid_frame_reach", rx_n[1] == 2 && ph[1] == 14, 1);
        rst[1] = 1'b1;
        cyc(3);
        rst[1] = 1'b0;
        cyc(60);
        check("abort_no_done", done_cnt[1], 3);
        fill_random(1);
        pulse(1);
        wait_done(1, 4, 8000);
        cyc(2);
        check("after_reset_count", rx_n[1], 124);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_dump_uart.md
REG_DUMP_UART -- requirements
Module: reg_dump_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868; clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIRST_REG, default 1; first register index dumped.
REQ-003 Parameter LAST_REG, default 31; last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin a dump.
REQ-007 rd_addr  output  5  register-file read-port address.
REQ-008 rd_data  input  32  combinational read data for rd_addr.
REQ-009 tx  output  1  UART serial line; idle high.
REQ-010 busy  output  1  high from the cycle after accepted start until done.
REQ-011 done  output  1  one-cycle pulse after the final stop bit.

Function
REQ-012 States SHALL be IDLE, ADDR, CAPTURE, SEND, NEXT.
REQ-013 IDLE: start=1 SHALL load the index counter with FIRST_REG, drive rd_addr=FIRST_REG, and go to ADDR; busy=1 next cycle.
REQ-014 start SHALL be ignored in every state other than IDLE.
REQ-015 ADDR -> CAPTURE after exactly one cycle; CAPTURE SHALL latch rd_data into a 32-bit snapshot and set byte counter to 0.
REQ-016 Snapshot SHALL be unaffected by rd_data changes after capture; the transmitted word is the value present in CAPTURE.
REQ-017 SEND SHALL transmit snapshot bytes big-endian: [31:24], [23:16], [15:8], [7:0].
REQ-018 Each byte SHALL be one 8N1 frame: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-019 Idle-high gap between consecutive frames, including across words, SHALL be at most 3 cycles.
REQ-020 After byte 3 stop bit: NEXT; if index == LAST_REG, done=1 for one cycle, busy=0, return to IDLE; else index+1, rd_addr updated, go to ADDR.
REQ-021 rd_addr SHALL hold the current index throughout ADDR, CAPTURE, SEND and NEXT; 0 in IDLE.
REQ-022 Total dump bytes = 4*(LAST_REG-FIRST_REG+1); default 124 bytes.
REQ-023 start in the same cycle done pulses SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-024 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and never wrap within a bit.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, tx=1, busy=0, done=0, rd_addr=0, all counters and snapshot to 0.
REQ-026 reset asserted mid-frame SHALL abort the dump; no partial frame resumes after release, and tx stays high until the next accepted start.
REQ-027 First rising clk edge after reset deassertion SHALL accept start.

Structure
REQ-028 Shared package SHALL hold state encoding constants, default CLKS_PER_BIT, and register-index width (5).
REQ-029 Sub-module uart_tx (inputs data[7:0], valid; outputs tx, ready) SHALL implement REQ-018; reg_dump_uart sequences words and bytes.
REQ-030 uart_tx SHALL accept a byte only when ready=1 and shall drive tx=1 when idle.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset assert/release, no start for 100 cycles -> tx=1, busy=0, done=0, rd_addr=0 throughout.
REQ-032 FIRST_REG=LAST_REG=5, reg5=0x12345678, start pulse -> bytes 0x12,0x34,0x56,0x78, each bit 4 cycles, start/stop bits correct, one done pulse, busy low next cycle.
REQ-033 Defaults, reg i = i*0x01010101 -> 124 bytes 0x01,0x01,0x01,0x01 ... 0x1F x4, rd_addr steps 1..31, exactly one done.
REQ-034 start pulses every 7 cycles during a dump -> byte stream identical to REQ-033, single done.
REQ-035 reg5 changed to 0xFFFFFFFF two cycles after CAPTURE -> bytes still 0x12,0x34,0x56,0x78.
REQ-036 reset asserted mid-data-bit of byte 2 -> tx=1 same cycle, busy=0, no further frames; fresh start yields full correct dump.
